fp_add_fu: RTL and testbench

Scoreboard functional unit for half-precision (IEEE 754 binary16) add/subtract. Accepts one issued instruction at a time and tracks operand readiness from the scoreboard broadcast. It reads both sources from the FP register file, runs the existing combinational adder `fpa` over a fixed multi-cycle execute window, and holds a write-back request until the scoreboard grants the result bus and clears WAR hazards. It sits between the scoreboard issue logic (upstream) and the register-file write port (downstream).

---
 rtl/fp_sb_pkg.sv | 33 +++
 rtl/fp_add_fu_if.sv | 47 ++++
 rtl/fp_add_fu_fpa.sv | 98 +++++++++
 rtl/fp_add_fu.sv | 133 +++++++++++++
 tb/tb_fp_add_fu.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_sb_pkg.sv
// Shared scoreboard/FP definitions: op encodings, tags, FU state, binary16 layout and constants.
package fp_sb_pkg;

    localparam int unsigned FP_W        = 16;
    localparam int unsigned EXP_W       = 5;
    localparam int unsigned MAN_W       = 10;
    localparam int unsigned FP_SIGN_BIT = 15;
    localparam int unsigned TAG_NONE    = 0;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [FP_W-1:0]  FP_ONE     = 16'h3C00;
    localparam logic [FP_W-1:0]  FP_INF     = 16'h7C00;
    localparam logic [FP_W-1:0]  FP_QNAN    = 16'h7E00;
    localparam logic [EXP_W-1:0] FP_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_OPS,
        ST_READ,
        ST_CAPT,
        ST_EXEC,
        ST_WB
    } fu_state_e;

endpackage

// File: rtl/fp_add_fu_if.sv
// Issue / CDB / register-file / write-back bundle between the scoreboard side and the FP add unit.
interface fp_add_fu_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned TAG_W    = 3
);
    localparam int unsigned RW = $clog2(NUM_REGS);

    logic             issue_valid;
    logic             issue_ready;
    logic             issue_op;
    logic [RW-1:0]    issue_fi;
    logic [RW-1:0]    issue_fj;
    logic [RW-1:0]    issue_fk;
    logic [TAG_W-1:0] issue_qj;
    logic [TAG_W-1:0] issue_qk;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             rf_rd_en;
    logic [RW-1:0]    rf_rd_addr_j;
    logic [RW-1:0]    rf_rd_addr_k;
    logic [15:0]      rf_rd_data_j;
    logic [15:0]      rf_rd_data_k;
    logic             rd_done;
    logic             war_clear;
    logic             wb_req;
    logic [RW-1:0]    wb_dest;
    logic [15:0]      wb_data;
    logic             wb_grant;
    logic             busy;

    // Scoreboard / register-file side
    modport master (
        output issue_valid, issue_op, issue_fi, issue_fj, issue_fk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, rf_rd_data_j, rf_rd_data_k, war_clear, wb_grant,
        input  issue_ready, rf_rd_en, rf_rd_addr_j, rf_rd_addr_k, rd_done,
        input  wb_req, wb_dest, wb_data, busy
    );

    // Functional-unit side
    modport slave (
        input  issue_valid, issue_op, issue_fi, issue_fj, issue_fk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, rf_rd_data_j, rf_rd_data_k, war_clear, wb_grant,
        output issue_ready, rf_rd_en, rf_rd_addr_j, rf_rd_addr_k, rd_done,
        output wb_req, wb_dest, wb_data, busy
    );

endinterface

// File: rtl/fp_add_fu_fpa.sv
// fpa: combinational binary16 adder, round-to-nearest-even, subnormals, canonical quiet NaN.
module fpa
    import fp_sb_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);
    // hidden bit + mantissa + guard/round/sticky
    localparam int unsigned GW = MAN_W + 4;
    localparam int unsigned MW = MAN_W + 2;

    fp16_t          xa, xb, xl, xs;
    logic           a_nan, b_nan, a_inf, b_inf;
    logic [5:0]     el, es, d, sh, e_n, e_f;
    logic [GW-1:0]  ml_ext, ms_ext, ms_al, lost, s_n;
    logic [GW:0]    sum;
    logic [4:0]     lz;
    logic           round_up;
    logic [MW-1:0]  m_r;
    logic [MAN_W-1:0] f_f;

    assign xa    = fp16_t'(a);
    assign xb    = fp16_t'(b);
    assign a_nan = (xa.exp == FP_EXP_MAX) && (xa.man != '0);
    assign b_nan = (xb.exp == FP_EXP_MAX) && (xb.man != '0);
    assign a_inf = (xa.exp == FP_EXP_MAX) && (xa.man == '0);
    assign b_inf = (xb.exp == FP_EXP_MAX) && (xb.man == '0);

    always_comb begin
        sh   = '0;
        lost = '0;
        // order by magnitude so the subtraction never goes negative
        if ({xb.exp, xb.man} > {xa.exp, xa.man}) begin
            xl = xb;
            xs = xa;
        end else begin
            xl = xa;
            xs = xb;
        end
        el     = (xl.exp == '0) ? 6'd1 : 6'(xl.exp);
        es     = (xs.exp == '0) ? 6'd1 : 6'(xs.exp);
        d      = el - es;
        ml_ext = {xl.exp != '0, xl.man, 3'b000};
        ms_ext = {xs.exp != '0, xs.man, 3'b000};

        if (d >= 6'(GW)) begin
            ms_al = GW'(|ms_ext);
        end else begin
            lost  = ms_ext & ((GW'(1) << d) - GW'(1));
            ms_al = (ms_ext >> d) | GW'(|lost);
        end

        if (xl.sign == xs.sign) sum = {1'b0, ml_ext} + {1'b0, ms_al};
        else                    sum = {1'b0, ml_ext} - {1'b0, ms_al};

        lz = 5'(GW);
        for (int i = 0; i < int'(GW); i++) begin
            if (sum[i]) lz = 5'(int'(GW) - 1 - i);
        end

        // left shift stops at the minimum exponent, which yields subnormals naturally
        if (sum[GW]) begin
            s_n = sum[GW:1] | GW'(sum[0]);
            e_n = el + 6'd1;
        end else begin
            sh  = (6'(lz) > (el - 6'd1)) ? (el - 6'd1) : 6'(lz);
            s_n = sum[GW-1:0] << sh;
            e_n = el - sh;
        end

        round_up = s_n[2] & (s_n[1] | s_n[0] | s_n[3]);
        m_r      = {1'b0, s_n[GW-1:3]} + MW'(round_up);
        if (m_r[MW-1]) begin
            e_f = e_n + 6'd1;
            f_f = m_r[MAN_W:1];
        end else begin
            e_f = m_r[MAN_W] ? e_n : 6'd0;
            f_f = m_r[MAN_W-1:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (xa.sign != xb.sign))) begin
            y = FP_QNAN;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (sum == '0) begin
            y = {xl.sign & xs.sign, 15'd0};
        end else if (e_f >= 6'd31) begin
            y = FP_INF;
            y[FP_SIGN_BIT] = xl.sign;
        end else begin
            y = {xl.sign, e_f[EXP_W-1:0], f_f};
        end
    end

endmodule

// File: rtl/fp_add_fu.sv
// Scoreboard FP add/sub unit: operand tracking, RF read, fixed-latency execute, held write-back.
module fp_add_fu
    import fp_sb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned TAG_W    = 3,
    parameter int unsigned EXEC_LAT = 3
) (
    input logic        clk,
    input logic        rst,
    fp_add_fu_if.slave bus
);
    localparam int unsigned RW    = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 3;

    fu_state_e        state;
    logic             op_q;
    logic [RW-1:0]    fi_q, fj_q, fk_q;
    logic [TAG_W-1:0] qj_q, qk_q;
    logic             rj_q, rk_q;
    logic [FP_W-1:0]  a_q, b_q, wb_data_q, fpa_y;
    logic [CNT_W-1:0] cnt_q;
    logic             issue_ready_q, rf_rd_en_q, rd_done_q, in_wb_q;
    logic             issue_hs, rj_hit, rk_hit, rj_wait, rk_wait;

    assign issue_hs = bus.issue_valid & issue_ready_q;
    assign rj_hit   = (bus.issue_qj == TAG_W'(TAG_NONE)) | (bus.cdb_valid & (bus.cdb_tag == bus.issue_qj));
    assign rk_hit   = (bus.issue_qk == TAG_W'(TAG_NONE)) | (bus.cdb_valid & (bus.cdb_tag == bus.issue_qk));
    assign rj_wait  = rj_q | (bus.cdb_valid & (bus.cdb_tag == qj_q));
    assign rk_wait  = rk_q | (bus.cdb_valid & (bus.cdb_tag == qk_q));

    fpa u_fpa (
        .a (a_q),
        .b (b_q),
        .y (fpa_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            op_q          <= 1'b0;
            fi_q          <= '0;
            fj_q          <= '0;
            fk_q          <= '0;
            qj_q          <= '0;
            qk_q          <= '0;
            rj_q          <= 1'b0;
            rk_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            wb_data_q     <= '0;
            issue_ready_q <= 1'b1;
            rf_rd_en_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            in_wb_q       <= 1'b0;
        end else begin
            rf_rd_en_q <= 1'b0;
            rd_done_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (issue_hs) begin
                        op_q          <= bus.issue_op;
                        fi_q          <= bus.issue_fi;
                        fj_q          <= bus.issue_fj;
                        fk_q          <= bus.issue_fk;
                        qj_q          <= bus.issue_qj;
                        qk_q          <= bus.issue_qk;
                        rj_q          <= rj_hit;
                        rk_q          <= rk_hit;
                        issue_ready_q <= 1'b0;
                        if (rj_hit && rk_hit) begin
                            state      <= ST_READ;
                            rf_rd_en_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT_OPS;
                        end
                    end
                end
                ST_WAIT_OPS: begin
                    rj_q <= rj_wait;
                    rk_q <= rk_wait;
                    if (rj_wait && rk_wait) begin
                        state      <= ST_READ;
                        rf_rd_en_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    state     <= ST_CAPT;
                    rd_done_q <= 1'b1;
                end
                ST_CAPT: begin
                    // subtraction is an add with the second operand's sign flipped
                    a_q   <= bus.rf_rd_data_j;
                    b_q   <= {bus.rf_rd_data_k[FP_SIGN_BIT] ^ (op_q == OP_SUB), bus.rf_rd_data_k[FP_SIGN_BIT-1:0]};
                    cnt_q <= CNT_W'(EXEC_LAT - 1);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        wb_data_q <= fpa_y;
                        in_wb_q   <= 1'b1;
                        state     <= ST_WB;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_WB: begin
                    if (bus.war_clear && bus.wb_grant) begin
                        in_wb_q       <= 1'b0;
                        issue_ready_q <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_ready  = issue_ready_q;
    assign bus.busy         = ~issue_ready_q;
    assign bus.rf_rd_en     = rf_rd_en_q;
    assign bus.rf_rd_addr_j = fj_q;
    assign bus.rf_rd_addr_k = fk_q;
    assign bus.rd_done      = rd_done_q;
    // request follows war_clear within the same cycle so a late clear costs no extra cycle
    assign bus.wb_req       = in_wb_q & bus.war_clear;
    assign bus.wb_dest      = fi_q;
    assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_fp_add_fu.sv
// Bench for fp_add_fu: directed timing steps plus random operands checked against a real-valued model.
module tb_fp_add_fu;
    import fp_sb_pkg::*;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] rf_mem [16];

    fp_add_fu_if #(.NUM_REGS(16), .TAG_W(3)) bus ();

    fp_add_fu #(.NUM_REGS(16), .TAG_W(3), .EXEC_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // register file: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rf_rd_en) begin
            bus.rf_rd_data_j <= rf_mem[bus.rf_rd_addr_j];
            bus.rf_rd_data_k <= rf_mem[bus.rf_rd_addr_k];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic real pow2(int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(logic [15:0] h);
        int  e = int'(h[14:10]);
        real m = real'(int'(h[9:0]));
        if (e != 0) m = m + 1024.0;
        else        e = 1;
        m = m * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    // exact sum in double precision, then rounded to binary16 with ties-to-even
    function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b, logic sub);
        logic [15:0] bb = b;
        real    x, y, fr;
        int     k;
        longint m, code;
        logic   s;
        if (sub) bb[15] = ~bb[15];
        x = h2r(a) + h2r(bb);
        if (x == 0.0) return {a[15] & bb[15], 15'd0};
        s = (x < 0.0);
        y = (s ? -x : x) * pow2(24);
        k = 0;
        while (y >= 2048.0) begin
            y = y / 2.0;
            k++;
        end
        m  = longint'($floor(y));
        fr = y - real'(m);
        if (fr > 0.5 || (fr == 0.5 && m[0])) m++;
        code = longint'(k) * 1024 + m;
        if (code >= 31744) return {s, 15'h7C00};
        return {s, 15'(code)};
    endfunction

    function automatic logic [15:0] rand_half();
        return {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
    endfunction

    function automatic logic [15:0] rand_near(logic [15:0] a);
        int e = int'(a[14:10]) + int'($urandom_range(0, 2)) - 1;
        if (e < 0)  e = 0;
        if (e > 30) e = 30;
        return {1'($urandom), 5'(e), 10'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_issue(logic op, int fi, int fj, int fk, int qj, int qk);
        chk("issue_ready", 32'(bus.issue_ready), 1);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_fi    = 4'(fi);
        bus.issue_fj    = 4'(fj);
        bus.issue_fk    = 4'(fk);
        bus.issue_qj    = 3'(qj);
        bus.issue_qk    = 3'(qk);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
    endtask

    // called in the cycle where the read strobe is due; runs to completion of write-back
    task automatic drain(logic [15:0] exp, int fi, int fj, int fk, int war_lo, int gdelay);
        chk("rf_rd_en", 32'(bus.rf_rd_en), 1);
        chk("rd_addr_j", 32'(bus.rf_rd_addr_j), 32'(fj));
        chk("rd_addr_k", 32'(bus.rf_rd_addr_k), 32'(fk));
        tick();
        chk("rd_done", 32'(bus.rd_done), 1);
        chk("rf_rd_en_once", 32'(bus.rf_rd_en), 0);
        tick();
        chk("rd_done_pulse", 32'(bus.rd_done), 0);
        for (int i = 0; i < L - 1; i++) tick();
        chk("wb_req_exec", 32'(bus.wb_req), 0);
        chk("busy_exec", 32'(bus.busy), 1);
        tick();
        for (int i = 0; i < war_lo; i++) begin
            bus.war_clear = 1'b0;
            bus.wb_grant  = 1'b1;
            #1;
            chk("wb_req_war_low", 32'(bus.wb_req), 0);
            chk("wb_data_war_low", 32'(bus.wb_data), 32'(exp));
            tick();
        end
        for (int i = 0; i < gdelay; i++) begin
            bus.war_clear = 1'b1;
            bus.wb_grant  = 1'b0;
            #1;
            chk("wb_req_held", 32'(bus.wb_req), 1);
            chk("wb_data_stable", 32'(bus.wb_data), 32'(exp));
            tick();
        end
        bus.war_clear = 1'b1;
        bus.wb_grant  = 1'b1;
        #1;
        chk("wb_req", 32'(bus.wb_req), 1);
        chk("wb_data", 32'(bus.wb_data), 32'(exp));
        chk("wb_dest", 32'(bus.wb_dest), 32'(fi));
        tick();
        chk("issue_ready_back", 32'(bus.issue_ready), 1);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("wb_req_idle", 32'(bus.wb_req), 0);
    endtask

    initial begin
        logic [15:0] exp;
        int fi, fj, fk, op, tag, dl, sel;

        rst = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 1'b0;
        bus.issue_fi    = '0;
        bus.issue_fj    = '0;
        bus.issue_fk    = '0;
        bus.issue_qj    = '0;
        bus.issue_qk    = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.war_clear   = 1'b1;
        bus.wb_grant    = 1'b1;
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'(i) << 8;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wb_req", 32'(bus.wb_req), 0);
        chk("rst_rd_done", 32'(bus.rd_done), 0);
        chk("rst_rf_rd_en", 32'(bus.rf_rd_en), 0);
        chk("rst_wb_data", 32'(bus.wb_data), 0);

        // 1.0 + 2.0
        rf_mem[1] = FP_ONE;
        rf_mem[2] = 16'h4000;
        do_issue(OP_ADD, 5, 1, 2, 0, 0);
        drain(16'h4200, 5, 1, 2, 0, 0);

        // 3.0 - 1.0 and 1.0 - 1.0
        rf_mem[3] = 16'h4200;
        do_issue(OP_SUB, 6, 3, 1, 0, 0);
        drain(16'h4000, 6, 3, 1, 0, 0);
        do_issue(OP_SUB, 7, 1, 1, 0, 0);
        drain(16'h0000, 7, 1, 1, 0, 0);

        // wait on tag 2; tag 3 broadcast is ignored
        do_issue(OP_ADD, 8, 1, 2, 2, 0);
        chk("wait_t1", 32'(bus.rf_rd_en), 0);
        tick();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd3;
        chk("wait_t2", 32'(bus.rf_rd_en), 0);
        tick();
        bus.cdb_valid = 1'b0;
        chk("wait_t3", 32'(bus.rf_rd_en), 0);
        tick();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd2;
        chk("wait_t4", 32'(bus.rf_rd_en), 0);
        tick();
        bus.cdb_valid = 1'b0;
        drain(16'h4200, 8, 1, 2, 0, 0);

        // broadcast in the issue cycle counts
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd2;
        do_issue(OP_ADD, 9, 2, 1, 2, 0);
        drain(16'h4200, 9, 2, 1, 0, 0);

        // one broadcast releases both sources
        do_issue(OP_SUB, 10, 2, 3, 5, 5);
        chk("both_wait", 32'(bus.rf_rd_en), 0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd5;
        tick();
        bus.cdb_valid = 1'b0;
        drain(16'hBC00, 10, 2, 3, 0, 0);

        // WAR hold then withheld grant
        do_issue(OP_ADD, 11, 1, 1, 0, 0);
        drain(16'h4000, 11, 1, 1, 3, 0);
        do_issue(OP_ADD, 12, 3, 2, 0, 0);
        drain(16'h4500, 12, 3, 2, 0, 5);

        // reset in second EXEC cycle
        do_issue(OP_ADD, 13, 1, 2, 0, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_wb_req", 32'(bus.wb_req), 0);
        chk("mid_rst_rd_done", 32'(bus.rd_done), 0);
        chk("mid_rst_wb_data", 32'(bus.wb_data), 0);
        do_issue(OP_SUB, 14, 2, 1, 0, 0);
        drain(16'h3C00, 14, 2, 1, 0, 0);

        // random operands, readiness and write-back back-pressure
        for (int n = 0; n < 40; n++) begin
            fi = int'($urandom_range(0, 15));
            fj = int'($urandom_range(0, 15));
            fk = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 1));
            rf_mem[fj] = rand_half();
            sel = int'($urandom_range(0, 9));
            if (fk != fj) begin
                if (sel == 0)     rf_mem[fk] = rf_mem[fj];
                else if (sel < 6) rf_mem[fk] = rand_near(rf_mem[fj]);
                else              rf_mem[fk] = rand_half();
            end
            exp = ref_add(rf_mem[fj], rf_mem[fk], 1'(op));
            tag = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            do_issue(1'(op), fi, fj, fk, tag, 0);
            if (tag != 0) begin
                dl = int'($urandom_range(0, 3));
                for (int i = 0; i < dl; i++) begin
                    chk("rand_wait", 32'(bus.rf_rd_en), 0);
                    tick();
                end
                bus.cdb_valid = 1'b1;
                bus.cdb_tag   = 3'(tag);
                chk("rand_wait_last", 32'(bus.rf_rd_en), 0);
                tick();
                bus.cdb_valid = 1'b0;
            end
            drain(exp, fi, fj, fk, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
